// File: rtl/svm_r_stream_wrapper.sv
// Stream front/back end for a combinational SVM-R classifier: serial feature load, settle, score capture.
// Optional macro SVM_R_NEAREST_ROUND_EN selects round-to-nearest (half rounds down); default truncates.
module svm_r_stream_wrapper #(
  parameter int unsigned WIDTH_A       = 4,
  parameter int unsigned NUM_A         = 11,
  parameter int unsigned OUTWIDTH      = 14,
  parameter int unsigned FRAC_BITS     = 9,
  parameter int unsigned MAX_CLASS     = 8,
  parameter int unsigned CLS_W         = 4,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [WIDTH_A-1:0]         s_data,
  input  logic                       s_last,
  output logic [NUM_A*WIDTH_A-1:0]   inp,
  input  logic [OUTWIDTH-1:0]        out_raw,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [CLS_W-1:0]           m_class,
  output logic [OUTWIDTH-1:0]        m_raw,
  output logic                       frame_err
);

  localparam int unsigned IDX_W = (NUM_A > 1) ? $clog2(NUM_A) : 1;
  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned INT_W = OUTWIDTH - FRAC_BITS + 1;
  localparam int unsigned VEC_W = NUM_A * WIDTH_A;

  typedef enum logic [1:0] {ST_LOAD, ST_SETTLE, ST_OUT} state_t;

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     idx, idx_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [VEC_W-1:0]     inp_nxt;
  logic                 s_ready_nxt, m_valid_nxt, frame_err_nxt;
  logic [CLS_W-1:0]     m_class_nxt;
  logic [OUTWIDTH-1:0]  m_raw_nxt;

  logic                 beat_c, last_idx_c, good_end_c, bad_frame_c;
  logic [INT_W-1:0]     int_part_c, rounded_c;
  logic [CLS_W-1:0]     cls_c;

  assign beat_c      = s_valid && s_ready && (state == ST_LOAD);
  assign last_idx_c  = (idx == IDX_W'(NUM_A - 1));
  assign good_end_c  = beat_c && last_idx_c && s_last;
  assign bad_frame_c = beat_c && (s_last != last_idx_c);

  // Score to class: integer part, optional rounding, then saturation at MAX_CLASS.
  assign int_part_c = INT_W'(out_raw >> FRAC_BITS);
`ifdef SVM_R_NEAREST_ROUND_EN
  localparam logic [FRAC_BITS-1:0] HALF = FRAC_BITS'(1) << (FRAC_BITS - 1);
  assign rounded_c = int_part_c + INT_W'(out_raw[FRAC_BITS-1:0] > HALF);
`else
  assign rounded_c = int_part_c;
`endif
  assign cls_c = (rounded_c > INT_W'(MAX_CLASS)) ? CLS_W'(MAX_CLASS) : CLS_W'(rounded_c);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_LOAD;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD:   if (good_end_c) state_nxt = ST_SETTLE;
      ST_SETTLE: if (cnt == '0) state_nxt = ST_OUT;
      ST_OUT:    if (m_ready) state_nxt = ST_LOAD;
      default:   state_nxt = ST_LOAD;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    idx_nxt       = idx;
    cnt_nxt       = cnt;
    inp_nxt       = inp;
    m_valid_nxt   = m_valid;
    m_class_nxt   = m_class;
    m_raw_nxt     = m_raw;
    frame_err_nxt = 1'b0;
    case (state)
      ST_LOAD: begin
        if (beat_c) begin
          for (int i = 0; i < NUM_A; i++) begin
            if (idx == IDX_W'(i)) inp_nxt[i*WIDTH_A +: WIDTH_A] = s_data;
          end
          if (bad_frame_c) begin
            idx_nxt       = '0;
            frame_err_nxt = 1'b1;
          end else if (good_end_c) begin
            idx_nxt = '0;
            cnt_nxt = CNT_W'(SETTLE_CYCLES - 1);
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
      ST_SETTLE: begin
        if (cnt == '0) begin
          m_raw_nxt   = out_raw;
          m_class_nxt = cls_c;
          m_valid_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_OUT: begin
        if (m_ready) begin
          m_valid_nxt = 1'b0;
          idx_nxt     = '0;
        end
      end
      default: begin
        idx_nxt     = '0;
        m_valid_nxt = 1'b0;
      end
    endcase
    s_ready_nxt = (state_nxt == ST_LOAD);
  end

  // Registered datapath and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      cnt       <= '0;
      inp       <= '0;
      s_ready   <= 1'b1;
      m_valid   <= 1'b0;
      m_class   <= '0;
      m_raw     <= '0;
      frame_err <= 1'b0;
    end else begin
      idx       <= idx_nxt;
      cnt       <= cnt_nxt;
      inp       <= inp_nxt;
      s_ready   <= s_ready_nxt;
      m_valid   <= m_valid_nxt;
      m_class   <= m_class_nxt;
      m_raw     <= m_raw_nxt;
      frame_err <= frame_err_nxt;
    end
  end

endmodule

// File: doc/svm_r_stream_wrapper.md
Name: svm_r_stream_wrapper

Overview:
- Sequential front/back end for a combinational printed regression classifier (SVM-R: NUM_A features in, one fixed-point score out).
- Receives features serially over a valid/ready stream and assembles them into the packed input vector.
- Holds that vector stable for a programmable settle time, then captures the raw score.
- Rounds and saturates the score to an integer class, and returns the class over a valid/ready result stream.

Parameters:
- WIDTH_A, 4: bits per feature.
- NUM_A, 11: features per sample.
- OUTWIDTH, 14: width of raw classifier score (unsigned).
- FRAC_BITS, 9: fractional bits of raw score.
- MAX_CLASS, 8: saturation ceiling for class output.
- CLS_W, 4: class output width; must hold MAX_CLASS.
- SETTLE_CYCLES, 4: cycles the input vector is held before capture; must be >= 1.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  feature beat valid.
- s_ready  out  1  block accepts feature beat.
- s_data  in  WIDTH_A  feature value, unsigned.
- s_last  in  1  marks final feature of a sample.
- inp  out  NUM_A*WIDTH_A  packed vector to classifier; feature i at bits [(i+1)*WIDTH_A-1 : i*WIDTH_A].
- out_raw  in  OUTWIDTH  raw score from classifier.
- m_valid  out  1  result valid.
- m_ready  in  1  result consumer ready.
- m_class  out  CLS_W  rounded, saturated class.
- m_raw  out  OUTWIDTH  captured raw score.
- frame_err  out  1  one-cycle pulse on framing error.

Behaviour:
- Reset (async assert, sync-safe deassert handled externally): state LOAD, beat index 0, inp=0, m_valid=0, m_class=0, m_raw=0, frame_err=0, s_ready=1 after reset release.
- FSM LOAD:
  - s_ready=1.
  - On s_valid&s_ready, s_data is written to feature slot [index] and index increments.
  - s_last on beat index<NUM_A-1, or s_last low on beat NUM_A-1, is a framing error:
    - frame_err pulses for 1 cycle;
    - index returns to 0;
    - inp keeps partially written values;
    - state stays LOAD.
  - On a correct final beat (index NUM_A-1 with s_last=1): go to SETTLE, settle counter=SETTLE_CYCLES-1.
- FSM SETTLE:
  - s_ready=0; inp held constant.
  - Counter decrements each cycle.
  - On the cycle the counter is 0: capture out_raw into m_raw, compute m_class, set m_valid=1, go to OUT.
  - Latency: m_valid rises exactly SETTLE_CYCLES clock edges after the final-beat handshake edge.
- FSM OUT:
  - s_ready=0; m_valid=1; m_class, m_raw and inp stable.
  - On m_valid&m_ready: m_valid=0, index=0, go to LOAD on the next edge.
  - m_ready held low keeps OUT indefinitely.
- Class arithmetic (unsigned):
  - int = out_raw >> FRAC_BITS.
  - frac = out_raw[FRAC_BITS-1:0].
  - half = 1 << (FRAC_BITS-1).
  - rounded = int + (frac > half ? 1 : 0); exactly half rounds down.
  - m_class = min(rounded, MAX_CLASS); saturation applies in every case.
  - Compute at width OUTWIDTH-FRAC_BITS+1 so no wrap occurs.
- Simultaneous events:
  - s_valid is ignored outside LOAD.
  - m_ready is ignored outside OUT.
  - frame_err and a state change never coincide.
- Reset mid-operation: any state returns to the reset values immediately; a partial or pending sample is discarded.

Optional Feature:
- Macro: SVM_R_NEAREST_ROUND_EN.
- Defined: rounding as above (frac > half increments int).
- Undefined: truncation, rounded = int, then saturated to MAX_CLASS; frac is ignored.

Test Plan:
- Reset, then features 1..11 with s_last on beat 11, out_raw=1793 (3*512+257), SETTLE_CYCLES=4 -> inp=0xBA987654321, m_valid high 4 edges after last beat, m_class=4 (3 if macro undefined), m_raw=1793.
- out_raw=1792 (exact half) -> m_class=3; out_raw=4396 (8*512+300) -> m_class=8; out_raw=16383 -> m_class=8; out_raw=0 -> m_class=0.
- Result produced with m_ready low for 5 cycles -> m_valid, m_class, m_raw and inp stable, s_ready=0 throughout; m_ready high -> m_valid falls next edge, s_ready=1.
- s_last asserted on beat 5 -> single-cycle frame_err, no m_valid; a following clean 11-beat frame -> correct result. Also s_last missing on beat 11 -> frame_err.
- s_valid toggled randomly (gaps) across 11 beats -> identical inp and result to a gapless frame.
- rst_n pulsed low during SETTLE and during OUT -> m_valid=0, inp=0, s_ready=1 after release; next frame processes normally.
